// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
// Contents:
//   state_t     controller state encoding (ST_RUN=0, ST_BUSY=1)
//   PHC_REG_W   default register-address width
//   NOP_INSTR   instruction word loaded by IF/ID flush and ID/EX bubble consumers
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int PHC_REG_W = 5;

    // sll $0,$0,0 - the canonical MIPS NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating up-counter for performance events
// Ports:
//   Clock  in   rising-edge clock
//   Reset  in   synchronous active-high clear
//   Inc    in   count one event on this edge
//   Count  out  event count, holds at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Count <= '0;
        end else if (Inc && (Count != {W{1'b1}})) begin
            Count <= Count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - IF/ID and ID/EX sequencing: load-use stall, MUL/DIV hold, branch flush
// Ports:
//   Clock, Reset                     rising-edge clock, synchronous active-high reset
//   ID_Rs, ID_Rt, ID_UsesRt          source operands of the instruction in ID
//   EX_MemRead, EX_Rt                load in EX and its destination register
//   EX_MulDivStart                   MUL/DIV occupying EX
//   BranchTaken                      branch/jump resolved taken in EX
//   PCWrite, IF_ID_Write             front-end write-enables
//   IF_ID_Flush, ID_EX_Bubble        NOP insertion into IF/ID and ID/EX
//   EX_Hold                          freeze ID/EX and the EX unit
//   StallCount, FlushCount           saturating performance counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16,
    parameter int REG_W      = PHC_REG_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_Rt,
    input  logic             EX_MulDivStart,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             EX_Hold,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // Down-counter must hold MULDIV_LAT-1; keep at least one bit for MULDIV_LAT=2.
    localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          load_use;

    // $zero is never a real producer, so a load to r0 cannot create a hazard.
    assign load_use = EX_MemRead && (EX_Rt != '0) &&
                      ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        EX_Hold      = 1'b0;
        if (!Reset) begin
            case (state)
                ST_RUN: begin
                    if (BranchTaken) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else if (EX_MulDivStart) begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        EX_Hold     = 1'b1;
                    end else if (load_use) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end
                end
                ST_BUSY: begin
                    // Last BUSY cycle (cnt==1) releases the front end while the
                    // MUL/DIV finishes its final EX cycle.
                    if (cnt > CW'(1)) begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        EX_Hold     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!BranchTaken && EX_MulDivStart) begin
                        cnt   <= CW'(MULDIV_LAT - 1);
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt > CW'(1)) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .Inc   (~PCWrite),
        .Count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .Inc   (IF_ID_Flush),
        .Count (FlushCount)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int LAT   = 4;
    localparam int CNT_W = 4;
    localparam int REG_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             Clock = 1'b0;
    logic             Reset;
    logic [REG_W-1:0] ID_Rs, ID_Rt, EX_Rt;
    logic             ID_UsesRt, EX_MemRead, EX_MulDivStart, BranchTaken;
    logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;

    // Reference: how many more cycles the current MUL/DIV occupies EX.
    int m_left;
    int m_stall;
    int m_flush;
    int hold_seen;

    always #5 Clock = ~Clock;

    pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .EX_MemRead     (EX_MemRead),
        .EX_Rt          (EX_Rt),
        .EX_MulDivStart (EX_MulDivStart),
        .BranchTaken    (BranchTaken),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .EX_Hold        (EX_Hold),
        .StallCount     (StallCount),
        .FlushCount     (FlushCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input int rs, input int rt, input logic uses_rt,
                         input logic mem_rd, input int ex_rt, input logic md, input logic br);
        Reset          = rst;
        ID_Rs          = REG_W'(rs);
        ID_Rt          = REG_W'(rt);
        ID_UsesRt      = uses_rt;
        EX_MemRead     = mem_rd;
        EX_Rt          = REG_W'(ex_rt);
        EX_MulDivStart = md;
        BranchTaken    = br;
    endtask

    // Called one time unit after a rising edge; checks at the falling edge,
    // advances the reference across the next rising edge.
    task automatic step();
        logic lu;
        logic [4:0] exp_ctrl;   // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold}
        #4;
        lu = EX_MemRead && (EX_Rt != 0) &&
             ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
        if (Reset)               exp_ctrl = 5'b11000;
        else if (m_left > 1)     exp_ctrl = 5'b00001;
        else if (m_left == 1)    exp_ctrl = 5'b11000;
        else if (BranchTaken)    exp_ctrl = 5'b11110;
        else if (EX_MulDivStart) exp_ctrl = 5'b00001;
        else if (lu)             exp_ctrl = 5'b00010;
        else                     exp_ctrl = 5'b11000;
        check("ctrl", {27'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold},
              {27'd0, exp_ctrl});
        check("stall_count", 32'(StallCount), 32'(m_stall));
        check("flush_count", 32'(FlushCount), 32'(m_flush));
        if (EX_Hold) hold_seen++;
        if (Reset) begin
            m_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!exp_ctrl[4] && m_stall < CMAX) m_stall++;
            if (exp_ctrl[2] && m_flush < CMAX)  m_flush++;
            if (m_left > 0)                          m_left--;
            else if (!BranchTaken && EX_MulDivStart) m_left = LAT - 1;
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        m_left = 0; m_stall = 0; m_flush = 0; hold_seen = 0;

        // Reset asserted for two cycles in the middle of a MUL/DIV hold
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        step();
        step();
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        step();
        step();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        #4;
        check("rst_ctrl", {27'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold},
              32'b11000);
        check("rst_stall", 32'(StallCount), 32'd0);
        check("rst_flush", 32'(FlushCount), 32'd0);
        @(posedge Clock);
        #1;

        // Load-use on rs: exactly one stall cycle
        do_reset();
        drive(1'b0, 8, 3, 1'b0, 1'b1, 8, 1'b0, 1'b0);
        step();
        drive(1'b0, 8, 3, 1'b0, 1'b0, 8, 1'b0, 1'b0);
        step();
        check("lu_rs_stall", 32'(StallCount), 32'd1);
        // Load into r0 never stalls
        drive(1'b0, 0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step();
        check("lu_r0_stall", 32'(StallCount), 32'd1);
        // rt match only counts when ID actually reads rt
        drive(1'b0, 2, 9, 1'b0, 1'b1, 9, 1'b0, 1'b0);
        step();
        check("rt_unused", 32'(StallCount), 32'd1);
        drive(1'b0, 2, 9, 1'b1, 1'b1, 9, 1'b0, 1'b0);
        step();
        check("rt_used", 32'(StallCount), 32'd2);

        // MUL/DIV held four cycles, branch pulse in the hold is ignored
        do_reset();
        hold_seen = 0;
        for (int i = 0; i < LAT; i++) begin
            drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, (i == 1));
            step();
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step();
        check("md_hold_cycles", 32'(hold_seen), 32'd3);
        check("md_stall", 32'(StallCount), 32'd3);
        check("md_no_flush", 32'(FlushCount), 32'd0);

        // Branch wins over a simultaneous load-use
        drive(1'b0, 8, 0, 1'b0, 1'b1, 8, 1'b0, 1'b1);
        step();
        check("br_flush", 32'(FlushCount), 32'd1);
        check("br_stall", 32'(StallCount), 32'd3);

        // Saturation after 20 load-use stalls
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 5, 0, 1'b0, 1'b1, 5, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step();
        check("sat_stall", 32'(StallCount), 32'(CMAX));

        // Randomized traffic against the reference
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
